// File: rtl/seven_seg_pattern_reader.sv
// ---------------------------------------------------------------------------
// seven_seg_pattern_reader
//
// Purpose:
//   Reads back a 7-segment display drive (gfedcba plus decimal point) and
//   recovers the bit index it encodes. It produces a 3-bit code and a
//   one-hot 8-bit word. The asynchronous inputs are synchronised, then
//   filtered for stability, then decoded. Each new stable pattern is
//   delivered once over a valid/ready handshake. A pattern equal to the
//   last reported one is never delivered again.
//
// Optional feature:
//   SEG_READER_ERRCNT_EN - when defined, adds port err_count. It is a
//                          saturating count of accepted results that had
//                          out_err set.
//
// Parameters:
//   STABLE_CYCLES  identical synced samples needed to accept a pattern (1..255)
//   SYNC_STAGES    synchroniser depth (2..3)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   seg_in     in   [6:0] segment lines gfedcba, bit0 = a (asynchronous)
//   dp_in      in   decimal point line, high = "no data set" (asynchronous)
//   out_ready  in   consumer accepts the result
//   out_valid  out  result valid
//   out_code   out  [2:0] decoded index
//   out_data   out  [7:0] one-hot 1<<out_code for a digit, else 0
//   out_none   out  blank pattern with dp set
//   out_err    out  illegal pattern
//   err_count  out  [7:0] saturating error count (SEG_READER_ERRCNT_EN only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module seven_seg_pattern_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] out_data,
    output logic       out_none,
    output logic       out_err
`ifdef SEG_READER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] C_CNT_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    // Decode result layout: {err, none, code[2:0], data[7:0]}.
    function automatic logic [12:0] f_decode(input logic [7:0] s);
        logic [2:0] code;
        logic       ok;
        code = 3'd0;
        ok   = 1'b1;
        case (s)
            8'h3F:   code = 3'd0;
            8'h06:   code = 3'd1;
            8'h5B:   code = 3'd2;
            8'h4F:   code = 3'd3;
            8'h66:   code = 3'd4;
            8'h6D:   code = 3'd5;
            8'h7D:   code = 3'd6;
            8'h07:   code = 3'd7;
            default: ok   = 1'b0;
        endcase
        if (ok) begin
            f_decode = {1'b0, 1'b0, code, 8'd1 << code};
        end else if (s == 8'h80) begin
            f_decode = {1'b0, 1'b1, 3'd0, 8'd0};
        end else begin
            f_decode = {1'b1, 1'b0, 3'd0, 8'd0};
        end
    endfunction

    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0]                  r_prev;
    logic [7:0]                  r_cnt;
    logic [7:0]                  r_last;
    logic                        r_last_vld;
    state_t                      r_state;
    logic                        r_valid;
    logic [2:0]                  r_code;
    logic [7:0]                  r_data;
    logic                        r_none;
    logic                        r_err;

    logic [7:0]  w_sample;
    logic        w_same;
    logic        w_stable;
    logic [12:0] w_dec;
    state_t      w_state_nxt;
    logic        w_valid_nxt;
    logic [2:0]  w_code_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_none_nxt;
    logic        w_err_nxt;
    logic [7:0]  w_last_nxt;
    logic        w_last_vld_nxt;

    assign w_sample = r_sync[SYNC_STAGES-1];
    assign w_same   = (w_sample == r_prev);
    // The equality term keeps a saturated counter from vouching for a sample
    // that has only just changed.
    assign w_stable = w_same && (r_cnt == C_CNT_MAX);
    assign w_dec    = f_decode(w_sample);

    // Input synchroniser: {dp, seg} shifted through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {dp_in, seg_in}};
        end
    end

    // Stability filter: count consecutive identical samples, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 8'd0;
            r_cnt  <= 8'd0;
        end else begin
            r_prev <= w_sample;
            if (!w_same) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // FSM and output/last-reported registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SETTLE;
            r_valid    <= 1'b0;
            r_code     <= 3'd0;
            r_data     <= 8'd0;
            r_none     <= 1'b0;
            r_err      <= 1'b0;
            r_last     <= 8'd0;
            r_last_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= w_valid_nxt;
            r_code     <= w_code_nxt;
            r_data     <= w_data_nxt;
            r_none     <= w_none_nxt;
            r_err      <= w_err_nxt;
            r_last     <= w_last_nxt;
            r_last_vld <= w_last_vld_nxt;
        end
    end

    // Next-state logic: capture a new stable pattern, hold it until accepted.
    always_comb begin
        w_state_nxt    = r_state;
        w_valid_nxt    = r_valid;
        w_code_nxt     = r_code;
        w_data_nxt     = r_data;
        w_none_nxt     = r_none;
        w_err_nxt      = r_err;
        w_last_nxt     = r_last;
        w_last_vld_nxt = r_last_vld;
        case (r_state)
            ST_SETTLE: begin
                if (w_stable && (!r_last_vld || (w_sample != r_last))) begin
                    w_err_nxt      = w_dec[12];
                    w_none_nxt     = w_dec[11];
                    w_code_nxt     = w_dec[10:8];
                    w_data_nxt     = w_dec[7:0];
                    w_last_nxt     = w_sample;
                    w_last_vld_nxt = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = ST_REPORT;
                end else begin
                    w_valid_nxt    = 1'b0;
                    w_state_nxt    = ST_SETTLE;
                end
            end
            ST_REPORT: begin
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_REPORT;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_SETTLE;
            end
        endcase
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign out_data  = r_data;
    assign out_none  = r_none;
    assign out_err   = r_err;

`ifdef SEG_READER_ERRCNT_EN
    logic [7:0] r_errcnt;

    // Saturating count of accepted error results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errcnt <= 8'd0;
        end else if (r_valid && out_ready && r_err && (r_errcnt != 8'hFF)) begin
            r_errcnt <= r_errcnt + 8'd1;
        end else begin
            r_errcnt <= r_errcnt;
        end
    end

    assign err_count = r_errcnt;
`endif

endmodule

// File: tb/tb_seven_seg_pattern_reader.sv
`timescale 1ns/1ps
module tb_seven_seg_pattern_reader;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [2:0] code;
        logic [7:0] data;
        logic       none;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       dp_in = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] out_data;
    logic       out_none;
    logic       out_err;
`ifdef SEG_READER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_reports = 0;
    vec_t exp_q[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    seven_seg_pattern_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dp_in     (dp_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_data  (out_data),
        .out_none  (out_none),
        .out_err   (out_err)
`ifdef SEG_READER_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] seg, input logic dp);
        seg_in = seg;
        dp_in  = dp;
    endtask

    task automatic push(input logic [2:0] code, input logic [7:0] data,
                        input logic none, input logic err);
        vec_t v;
        v.seg = 7'h00; v.dp = 1'b0;
        v.code = code; v.data = data; v.none = none; v.err = err;
        exp_q.push_back(v);
    endtask

    // Count ticks until out_valid rises (bounded) and compare with expected latency.
    task automatic wait_valid(input string name, input int exp_lat);
        int n;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (out_valid) break;
        end
        chk(name, n, exp_lat);
    endtask

    // Scoreboard: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_reports++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_report: got code %0d err %0b none %0b, expected no report",
                         out_code, out_err, out_none);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("sb_code", 32'(out_code), 32'(e.code));
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_none", 32'(out_none), 32'(e.none));
                chk("sb_err",  32'(out_err),  32'(e.err));
            end
        end
    end

    initial begin
        int base;
        tbl[0]  = '{7'h3F, 1'b0, 3'd0, 8'h01, 1'b0, 1'b0};
        tbl[1]  = '{7'h06, 1'b0, 3'd1, 8'h02, 1'b0, 1'b0};
        tbl[2]  = '{7'h5B, 1'b0, 3'd2, 8'h04, 1'b0, 1'b0};
        tbl[3]  = '{7'h4F, 1'b0, 3'd3, 8'h08, 1'b0, 1'b0};
        tbl[4]  = '{7'h66, 1'b0, 3'd4, 8'h10, 1'b0, 1'b0};
        tbl[5]  = '{7'h6D, 1'b0, 3'd5, 8'h20, 1'b0, 1'b0};
        tbl[6]  = '{7'h7D, 1'b0, 3'd6, 8'h40, 1'b0, 1'b0};
        tbl[7]  = '{7'h07, 1'b0, 3'd7, 8'h80, 1'b0, 1'b0};
        tbl[8]  = '{7'h00, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{7'h06, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1};
        tbl[10] = '{7'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        tbl[11] = '{7'h7F, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_code",  32'(out_code),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_flags", 32'({out_none, out_err}), 32'd0);

        // Single digit 2 after reset, latency 2+4+1
        rst_n = 1'b1;
        drive(7'h5B, 1'b0);
        push(3'd2, 8'h04, 1'b0, 1'b0);
        wait_valid("lat_first", 7);
        tick();
        chk("pulse_once", 32'(out_valid), 32'd0);
        repeat (8) tick();

        // Table: all digits, none and error patterns, each held 10 clocks
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].seg, tbl[i].dp);
            exp_q.push_back(tbl[i]);
            repeat (10) tick();
        end
`ifdef SEG_READER_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'd3);
`endif

        // Glitch: 3-clk pulse of 0x7D inside a stable 0x07
        base = n_reports;
        drive(7'h07, 1'b0);
        push(3'd7, 8'h80, 1'b0, 1'b0);
        repeat (12) tick();
        drive(7'h7D, 1'b0);
        repeat (3) tick();
        drive(7'h07, 1'b0);
        repeat (15) tick();
        chk("glitch_reports", n_reports - base, 1);

        // Back-pressure: hold code 4, change input, then accept
        out_ready = 1'b0;
        drive(7'h66, 1'b0);
        push(3'd4, 8'h10, 1'b0, 1'b0);
        wait_valid("lat_hold", 7);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_code", 32'(out_code), 32'd4);
        end
        drive(7'h6D, 1'b0);
        push(3'd5, 8'h20, 1'b0, 1'b0);
        repeat (10) tick();
        chk("still_code4", 32'(out_code), 32'd4);
        out_ready = 1'b1;
        tick();
        chk("gap_low", 32'(out_valid), 32'd0);
        tick();
        chk("next_valid", 32'(out_valid), 32'd1);
        chk("next_code", 32'(out_code), 32'd5);
        repeat (5) tick();

        // Reset during REPORT, then re-report of the unchanged input
        out_ready = 1'b0;
        drive(7'h4F, 1'b0);
        wait_valid("lat_pre_rst", 7);
        chk("pre_rst_code", 32'(out_code), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(3'd3, 8'h08, 1'b0, 1'b0);
        wait_valid("lat_after_rst", 7);
        repeat (5) tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
